// File: rtl/networkadapter_conf_arbiter_pkg.sv
// Shared types and defaults for the tile-configuration register arbiter.
package networkadapter_conf_arbiter_pkg;

  localparam int CONF_ADR_WIDTH  = 16;
  localparam int CONF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } conf_arb_state_t;

  // Index width for a master count; a single master still needs one bit.
  function automatic int conf_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/networkadapter_conf_arbiter_rr.sv
// Combinational round-robin pick: first requester after the last grant.
module conf_rr_arbiter
  import networkadapter_conf_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = conf_idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last_idx,
  output logic [NUM_MASTERS-1:0] gnt_oh,
  output logic [IDX_W-1:0]       gnt_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Search last+1, last+2, ... wrapping; the last grant is checked last.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = IDX_W'((int'(last_idx) + k) % NUM_MASTERS);
      if (!found && req[cand]) begin
        found        = 1'b1;
        gnt_oh[cand] = 1'b1;
        gnt_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/networkadapter_conf_arbiter.sv
// Arbitrates NUM_MASTERS Wishbone-classic masters onto the tile-config slave.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | wait for a request, pick a master, latch its request
// ACCESS | slave sees the latched request; s_we_o high only here
// RESP   | forward sampled response to granted master if still active
module networkadapter_conf_arbiter
  import networkadapter_conf_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADR_WIDTH   = CONF_ADR_WIDTH,
  parameter int DATA_WIDTH  = CONF_DATA_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_MASTERS-1:0]           m_cyc_i,
  input  logic [NUM_MASTERS-1:0]           m_stb_i,
  input  logic [NUM_MASTERS-1:0]           m_we_i,
  input  logic [NUM_MASTERS*ADR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  output logic [DATA_WIDTH-1:0]            m_dat_o,
  output logic [NUM_MASTERS-1:0]           m_ack_o,
  output logic [NUM_MASTERS-1:0]           m_err_o,
  output logic [NUM_MASTERS-1:0]           m_rty_o,
  output logic [ADR_WIDTH-1:0]             s_adr_o,
  output logic                             s_we_o,
  output logic [DATA_WIDTH-1:0]            s_dat_o,
  input  logic [DATA_WIDTH-1:0]            s_dat_i,
  input  logic                             s_ack_i,
  input  logic                             s_err_i,
  input  logic                             s_rty_i
);

  localparam int IDX_W = conf_idx_width(NUM_MASTERS);

  conf_arb_state_t        state_q;
  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] arb_gnt;
  logic [IDX_W-1:0]       arb_idx;
  logic [IDX_W-1:0]       grant_q;
  logic [IDX_W-1:0]       last_q;
  logic                   rsp_ack_q;
  logic                   rsp_err_q;
  logic                   rsp_rty_q;

  assign req = m_cyc_i & m_stb_i;

  conf_rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_rr (
    .req      (req),
    .last_idx (last_q),
    .gnt_oh   (arb_gnt),
    .gnt_idx  (arb_idx)
  );

  // Sequencer: latch request in IDLE, strobe slave in ACCESS, respond in RESP.
  // s_we_o is loaded on entry to ACCESS and cleared on exit, so a write
  // strobe can never last longer than one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= IDX_W'(NUM_MASTERS - 1);
      s_adr_o   <= '0;
      s_dat_o   <= '0;
      s_we_o    <= 1'b0;
      rsp_ack_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_rty_q <= 1'b0;
      m_dat_o   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|arb_gnt) begin
            grant_q <= arb_idx;
            s_adr_o <= m_adr_i[int'(arb_idx)*ADR_WIDTH +: ADR_WIDTH];
            s_dat_o <= m_dat_i[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
            s_we_o  <= m_we_i[arb_idx];
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          s_we_o    <= 1'b0;
          rsp_ack_q <= s_ack_i;
          rsp_err_q <= s_err_i;
          rsp_rty_q <= s_rty_i;
          // Read data is only replaced for a master that is still waiting,
          // so an aborted access leaves m_dat_o untouched.
          if (req[grant_q]) begin
            m_dat_o <= s_dat_i;
          end
          state_q <= RESP;
        end
        RESP: begin
          last_q  <= grant_q;
          state_q <= IDLE;
        end
        default: begin
          s_we_o  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Response steering: only the granted, still-active master sees a pulse.
  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    if (state_q == RESP && req[grant_q]) begin
      m_ack_o[grant_q] = rsp_ack_q;
      m_err_o[grant_q] = rsp_err_q;
      m_rty_o[grant_q] = rsp_rty_q;
    end
  end

endmodule

// File: tb/tb_networkadapter_conf_arbiter.sv
// Directed bench for the tile-config arbiter with two masters.
module tb_networkadapter_conf_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_cyc_i, m_stb_i, m_we_i;
  logic [31:0] m_adr_i;
  logic [63:0] m_dat_i;
  logic [31:0] m_dat_o;
  logic [1:0]  m_ack_o, m_err_o, m_rty_o;
  logic [15:0] s_adr_o;
  logic        s_we_o;
  logic [31:0] s_dat_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i, s_err_i, s_rty_i;

  int tests  = 0;
  int failed = 0;
  int acks0  = 0;
  int acks1  = 0;

  networkadapter_conf_arbiter #(
    .NUM_MASTERS (2),
    .ADR_WIDTH   (16),
    .DATA_WIDTH  (32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_cyc_i (m_cyc_i),
    .m_stb_i (m_stb_i),
    .m_we_i  (m_we_i),
    .m_adr_i (m_adr_i),
    .m_dat_i (m_dat_i),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .m_rty_o (m_rty_o),
    .s_adr_o (s_adr_o),
    .s_we_o  (s_we_o),
    .s_dat_o (s_dat_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .s_err_i (s_err_i),
    .s_rty_i (s_rty_i)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_masters();
    m_cyc_i = 2'b00;
    m_stb_i = 2'b00;
    m_we_i  = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    idle_masters();
    m_adr_i = '0;
    m_dat_i = '0;
    s_dat_i = '0;
    s_ack_i = 1'b0;
    s_err_i = 1'b0;
    s_rty_i = 1'b0;
    do_reset();

    // reset state
    chk("rst_ack",  64'(m_ack_o), 64'h0);
    chk("rst_err",  64'(m_err_o), 64'h0);
    chk("rst_rty",  64'(m_rty_o), 64'h0);
    chk("rst_we",   64'(s_we_o),  64'h0);
    chk("rst_adr",  64'(s_adr_o), 64'h0);
    chk("rst_sdat", 64'(s_dat_o), 64'h0);
    chk("rst_mdat", 64'(m_dat_o), 64'h0);

    // single read by master 0
    m_cyc_i = 2'b01; m_stb_i = 2'b01; m_we_i = 2'b00;
    m_adr_i = {16'h0000, 16'h0004};
    s_dat_i = 32'h10; s_ack_i = 1'b1;
    cycle();
    chk("rd_access_we",  64'(s_we_o),  64'h0);
    chk("rd_access_adr", 64'(s_adr_o), 64'h0004);
    chk("rd_access_ack", 64'(m_ack_o), 64'h0);
    cycle();
    chk("rd_resp_ack", 64'(m_ack_o), 64'h1);
    chk("rd_resp_dat", 64'(m_dat_o), 64'h10);
    chk("rd_resp_we",  64'(s_we_o),  64'h0);
    idle_masters();
    cycle();
    chk("rd_after_ack", 64'(m_ack_o), 64'h0);
    chk("rd_hold_dat",  64'(m_dat_o), 64'h10);

    // contention from a fresh reset: order 0,1,0,1
    do_reset();
    m_cyc_i = 2'b11; m_stb_i = 2'b11; m_we_i = 2'b00;
    m_adr_i = {16'h0020, 16'h0010};
    s_dat_i = 32'hAA; s_ack_i = 1'b1;
    for (int t = 0; t < 4; t++) begin
      cycle();
      chk("cont_access_ack", 64'(m_ack_o), 64'h0);
      chk("cont_adr", 64'(s_adr_o), (t % 2 == 0) ? 64'h0010 : 64'h0020);
      cycle();
      chk("cont_resp_ack", 64'(m_ack_o), (t % 2 == 0) ? 64'h1 : 64'h2);
      if (m_ack_o[0]) acks0++;
      if (m_ack_o[1]) acks1++;
      if (t == 3) idle_masters();
      cycle();
      chk("cont_idle_ack", 64'(m_ack_o), 64'h0);
    end
    chk("cont_acks0", 64'(acks0), 64'd2);
    chk("cont_acks1", 64'(acks1), 64'd2);

    // write pulse from master 1 (last grant was 1, only 1 requests)
    m_cyc_i = 2'b10; m_stb_i = 2'b10; m_we_i = 2'b10;
    m_adr_i = {16'h0108, 16'h0000};
    m_dat_i = {32'h5, 32'h0};
    chk("wr_idle_we", 64'(s_we_o), 64'h0);
    cycle();
    chk("wr_access_we",  64'(s_we_o),  64'h1);
    chk("wr_access_adr", 64'(s_adr_o), 64'h0108);
    chk("wr_access_dat", 64'(s_dat_o), 64'h5);
    chk("wr_access_ack", 64'(m_ack_o), 64'h0);
    cycle();
    chk("wr_resp_we",  64'(s_we_o),  64'h0);
    chk("wr_resp_ack", 64'(m_ack_o), 64'h2);
    idle_masters();
    cycle();
    chk("wr_idle2_we",  64'(s_we_o),  64'h0);
    chk("wr_idle2_ack", 64'(m_ack_o), 64'h0);

    // error pass-through for master 0
    m_cyc_i = 2'b01; m_stb_i = 2'b01; m_we_i = 2'b00;
    m_adr_i = {16'h0000, 16'h1000};
    s_dat_i = 32'hEE; s_ack_i = 1'b0; s_err_i = 1'b1;
    cycle();
    chk("err_access_err", 64'(m_err_o), 64'h0);
    cycle();
    chk("err_resp_err", 64'(m_err_o), 64'h1);
    chk("err_resp_ack", 64'(m_ack_o), 64'h0);
    chk("err_resp_rty", 64'(m_rty_o), 64'h0);
    idle_masters();
    s_err_i = 1'b0; s_ack_i = 1'b1;
    cycle();
    chk("err_after_err", 64'(m_err_o), 64'h0);

    // abort: master 0 drops during ACCESS, master 1 then gets granted
    m_cyc_i = 2'b01; m_stb_i = 2'b01; m_we_i = 2'b00;
    m_adr_i = {16'h0200, 16'h0040};
    cycle();
    chk("abt_access_adr", 64'(s_adr_o), 64'h0040);
    m_cyc_i = 2'b10; m_stb_i = 2'b10;
    s_dat_i = 32'h77;
    cycle();
    chk("abt_resp_ack", 64'(m_ack_o), 64'h0);
    chk("abt_resp_err", 64'(m_err_o), 64'h0);
    chk("abt_resp_rty", 64'(m_rty_o), 64'h0);
    chk("abt_resp_dat", 64'(m_dat_o), 64'hEE);
    cycle();
    chk("abt_idle_ack", 64'(m_ack_o), 64'h0);
    cycle();
    chk("abt_m1_adr", 64'(s_adr_o), 64'h0200);
    cycle();
    chk("abt_m1_ack", 64'(m_ack_o), 64'h2);
    chk("abt_m1_dat", 64'(m_dat_o), 64'h77);
    idle_masters();
    cycle();

    // reset during ACCESS of a write by master 1
    m_cyc_i = 2'b10; m_stb_i = 2'b10; m_we_i = 2'b10;
    m_adr_i = {16'h0300, 16'h0400};
    m_dat_i = {32'h9, 32'h0};
    cycle();
    chk("rstm_access_we", 64'(s_we_o), 64'h1);
    rst = 1'b1;
    cycle();
    chk("rstm_we",   64'(s_we_o),  64'h0);
    chk("rstm_adr",  64'(s_adr_o), 64'h0);
    chk("rstm_sdat", 64'(s_dat_o), 64'h0);
    chk("rstm_mdat", 64'(m_dat_o), 64'h0);
    chk("rstm_ack",  64'(m_ack_o), 64'h0);
    rst = 1'b0;
    m_cyc_i = 2'b11; m_stb_i = 2'b11; m_we_i = 2'b10;
    cycle();
    chk("rstm_next_adr", 64'(s_adr_o), 64'h0400);
    chk("rstm_next_we",  64'(s_we_o),  64'h0);
    cycle();
    chk("rstm_next_ack", 64'(m_ack_o), 64'h1);
    idle_masters();
    cycle();
    chk("rstm_end_ack", 64'(m_ack_o), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
